pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Consumes the `locked` output of the 12 MHz→50.25 MHz iCE40 PLL and qualifies it before the rest of the design may use `clock`. It holds the SID core in reset until lock has been stable, then releases the system reset. While running, it generates a fractional-rate clock-enable strobe (SID phi2, about 1 MHz) from a phase accumulator. It sits between the PLL wrapper and the SID core, and counts lock-loss events for debug.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronized-`locked`-high cycles required before reset release.
- RESET_HOLD, 16: cycles that `sys_reset_n` stays low after lock qualifies.
- ACC_WIDTH, 24: width of the phase accumulator.
- PHASE_INC, 333876: added per RUN cycle. Strobe rate = f_clock·PHASE_INC/2^ACC_WIDTH (≈1.000 MHz at 50.25 MHz). Legal range is 0..2^ACC_WIDTH-1.

Ports:
- clock  in  1  PLL output clock (clock_out of the PLL); sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- locked  in  1  PLL lock, asynchronous to `clock`.
- sys_reset_n  out  1  synchronous active-low reset to downstream logic.
- clk_en  out  1  one-cycle phi2 enable strobe.
- ready  out  1  high while in RUN.
- lock_lost_count  out  8  number of RUN→WAIT_LOCK transitions, saturating.

Behaviour:
- Reset values (reset_n=0, asynchronous):
  - state=WAIT_LOCK, sys_reset_n=0, clk_en=0, ready=0, lock_lost_count=0.
  - Accumulator, qualify/hold counter and synchronizer flops all cleared.
- All outputs are registered.
- `locked` passes through a 2-flop synchronizer to give lock_s (2-cycle latency).
- WAIT_LOCK:
  - counter=0; sys_reset_n=0.
  - lock_s=1 → QUALIFY.
- QUALIFY:
  - lock_s=0 → WAIT_LOCK, counter cleared.
  - Else if counter==STABLE_CYCLES-1 → HOLD, counter=0.
  - Else counter+1.
  - Occupies exactly STABLE_CYCLES cycles.
- HOLD:
  - sys_reset_n stays 0.
  - lock_s=0 → WAIT_LOCK.
  - Else if counter==RESET_HOLD-1 → RUN.
  - Else counter+1.
- RUN:
  - sys_reset_n=1 and ready=1 from the first RUN cycle.
  - lock_s=0 → WAIT_LOCK. On that edge: sys_reset_n=0, ready=0, clk_en=0, lock_lost_count+1, saturating at 255.
- Timing: if `locked` is high from edge N onward, QUALIFY is entered at edge N+2 and RUN at edge N+2+STABLE_CYCLES+RESET_HOLD.
- Phase accumulator:
  - acc is cleared to 0 on the edge entering RUN.
  - Each RUN cycle: {carry,acc} <= acc+PHASE_INC, computed ACC_WIDTH+1 wide with wrap-around modulo 2^ACC_WIDTH.
  - clk_en <= carry, so it is never high for two consecutive cycles unless PHASE_INC ≥ 2^(ACC_WIDTH-1).
  - Outside RUN: acc held at 0, clk_en=0.
  - PHASE_INC=0: clk_en never asserts.
- Simultaneous events: lock loss on the same cycle as a counter terminal count → lock loss wins (go to WAIT_LOCK, no advance).
- Glitch filtering: a lock_s low pulse of 1 cycle in QUALIFY or HOLD restarts qualification from WAIT_LOCK.
- Mid-operation reset: reset_n low clears everything immediately, including lock_lost_count.
- Degenerate parameters: STABLE_CYCLES=1 or RESET_HOLD=1 are legal (single-cycle states). 0 is illegal.

Test Plan:
- Reset sequence (STABLE_CYCLES=8, RESET_HOLD=4): reset_n low, `locked`=1 → all outputs 0 during reset. After release, with `locked` high from edge N: sys_reset_n and ready rise at edge N+14, not earlier.
- Glitch during QUALIFY: `locked` drops for 1 cycle at qualify count 5 → return to WAIT_LOCK. Full 8+4 cycle requalification before sys_reset_n=1. lock_lost_count stays 0.
- Strobe rate (ACC_WIDTH=4, PHASE_INC=4): in RUN, clk_en is high exactly on every 4th cycle, first pulse 4 cycles after RUN entry. 100 RUN cycles → 25 pulses.
- Fractional rate (ACC_WIDTH=4, PHASE_INC=3): 16 RUN cycles → exactly 3 pulses, pulse spacing 5 or 6 cycles.
- Lock loss in RUN: drop `locked` → sys_reset_n=0, clk_en=0, ready=0 two cycles later (synchronizer) plus one edge. lock_lost_count=1. Repeat 300 times → count saturates at 255.
- Async reset mid-RUN: pulse reset_n low between clock edges → outputs clear immediately, without waiting for a clock edge. lock_lost_count=0, and the block requalifies from WAIT_LOCK.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Lock-status bundle between the PLL wrapper, the supervisor and downstream logic.
// The master side is the PLL/consumer end and the slave side is the supervisor.
interface pll_lock_supervisor_if;
  logic       locked;
  logic       sys_reset_n;
  logic       clk_en;
  logic       ready;
  logic [7:0] lock_lost_count;

  modport master (output locked, input sys_reset_n, clk_en, ready, lock_lost_count);
  modport slave  (input locked, output sys_reset_n, clk_en, ready, lock_lost_count);
endinterface

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, sequences the downstream reset and generates the phi2 enable
// strobe from a phase accumulator while running. Lock-loss events are counted for debug.
module pll_lock_supervisor #(
  parameter int          STABLE_CYCLES = 1024,
  parameter int          RESET_HOLD    = 16,
  parameter int          ACC_WIDTH     = 24,
  parameter int unsigned PHASE_INC     = 333876
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pll_lock_supervisor_if.slave  bus
);

  localparam int CNT_MAX = (STABLE_CYCLES > RESET_HOLD) ? STABLE_CYCLES : RESET_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]      Q_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]      H_LAST = CW'(RESET_HOLD - 1);
  localparam logic [ACC_WIDTH:0] LP_INC = (ACC_WIDTH+1)'(PHASE_INC);

  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, HOLD, RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_sync;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 r_srn, r_rdy, r_en;
  logic                 w_run_nxt, w_en_nxt;
  logic [7:0]           r_lost, w_lost_nxt;
  logic                 w_lock_s;

  assign w_lock_s = r_sync[1];

  // State register, qualify/hold counter and the lock synchronizer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_sync  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sync  <= {r_sync[0], bus.locked};
    end
  end

  // Lock loss always wins over a terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      WAIT_LOCK: if (w_lock_s) w_state_nxt = QUALIFY;
      QUALIFY: begin
        if (!w_lock_s)             w_state_nxt = WAIT_LOCK;
        else if (r_cnt == Q_LAST)  w_state_nxt = HOLD;
        else                       w_cnt_nxt   = r_cnt + CW'(1);
      end
      HOLD: begin
        if (!w_lock_s)             w_state_nxt = WAIT_LOCK;
        else if (r_cnt == H_LAST)  w_state_nxt = RUN;
        else                       w_cnt_nxt   = r_cnt + CW'(1);
      end
      RUN:     if (!w_lock_s) w_state_nxt = WAIT_LOCK;
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Next values of the registered outputs; the accumulator only advances between RUN cycles,
  // so the RUN entry edge clears it and the exit edge forces the strobe low.
  always_comb begin
    w_run_nxt  = (w_state_nxt == RUN);
    w_sum      = {1'b0, r_acc} + LP_INC;
    w_acc_nxt  = '0;
    w_en_nxt   = 1'b0;
    if (r_state == RUN && w_run_nxt) begin
      w_acc_nxt = w_sum[ACC_WIDTH-1:0];
      w_en_nxt  = w_sum[ACC_WIDTH];
    end
    w_lost_nxt = r_lost;
    if (r_state == RUN && !w_run_nxt && r_lost != 8'hFF) w_lost_nxt = r_lost + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_srn  <= 1'b0;
      r_rdy  <= 1'b0;
      r_en   <= 1'b0;
      r_acc  <= '0;
      r_lost <= '0;
    end else begin
      r_srn  <= w_run_nxt;
      r_rdy  <= w_run_nxt;
      r_en   <= w_en_nxt;
      r_acc  <= w_acc_nxt;
      r_lost <= w_lost_nxt;
    end
  end

  assign bus.sys_reset_n     = r_srn;
  assign bus.ready           = r_rdy;
  assign bus.clk_en          = r_en;
  assign bus.lock_lost_count = r_lost;

endmodule
